// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer that owns
// every write into the HI/LO register pair. It holds EX with stallreq while
// busy and emits a single-cycle {hi_we, lo_we, hi_in, lo_in} write bus.
module hilo_md_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        stallreq,
  output logic        busy,
  output logic [65:0] hilo_bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [4:0] cnt;
  logic       hi_we_r, lo_we_r;

  // Operand and result registers (data path, not reset).
  logic signed [31:0] mul_a_p0, mul_b_p0;
  logic               mul_sgn_p0;
  logic [31:0]        div_b_p0;
  logic               neg_q, neg_r;
  // hi_r doubles as the partial remainder and lo_r as the shifting
  // dividend/quotient while dividing; both hold the final result in DONE.
  logic [31:0]        hi_r, lo_r;

  // Two's-complement magnitude of a 32-bit value; 0x80000000 maps onto itself,
  // which the unsigned divide path interprets correctly as 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's-complement negation used for the signed-divide fix-up.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic n);
    cond_neg = n ? (~v + 32'd1) : v;
  endfunction

  logic is_mul, is_div, is_mt, op_valid, div_zero, accept;

  assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div   = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_mt    = (op == OP_MTHI) || (op == OP_MTLO);
  assign op_valid = is_mul || is_div || is_mt;
  assign div_zero = (src_b == 32'd0);
  assign accept   = (state == S_IDLE) && start && !cancel && op_valid;

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  logic [32:0] rem_sh, rem_diff;
  logic        q_bit;

  assign rem_sh   = {hi_r, lo_r[31]};
  assign rem_diff = rem_sh - {1'b0, div_b_p0};
  assign q_bit    = !rem_diff[32];

  // Full 64-bit product; sign extension is controlled by mul_sgn_p0.
  logic signed [32:0] mul_ax, mul_bx;
  logic signed [63:0] product;

  assign mul_ax  = {mul_sgn_p0 & mul_a_p0[31], mul_a_p0};
  assign mul_bx  = {mul_sgn_p0 & mul_b_p0[31], mul_b_p0};
  assign product = 64'(mul_ax) * 64'(mul_bx);

  // Next-state and stall request; stall drops in DONE so EX advances as the write lands.
  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_nxt = S_MUL;
            stallreq  = 1'b1;
          end else if (is_div && !div_zero) begin
            state_nxt = S_DIV;
            stallreq  = 1'b1;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_MUL: begin
        stallreq  = !cancel;
        state_nxt = cancel ? S_IDLE : S_DONE;
      end
      S_DIV: begin
        stallreq = !cancel;
        if (cancel)
          state_nxt = S_IDLE;
        else if (cnt == 5'd31)
          state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state: FSM, iteration counter and write enables for the pending op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 5'd0;
      hi_we_r <= 1'b0;
      lo_we_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= 5'd0;
        hi_we_r <= (op != OP_MTLO);
        lo_we_r <= (op != OP_MTHI);
      end else if (state == S_DIV) begin
        cnt <= cnt + 5'd1;
      end
    end
  end

  // Data path: latch operands on accept, then multiply or iterate the divider.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      if (is_mul) begin
        mul_a_p0   <= signed'(src_a);
        mul_b_p0   <= signed'(src_b);
        mul_sgn_p0 <= (op == OP_MULT);
      end else if (is_div && !div_zero) begin
        hi_r     <= 32'd0;
        lo_r     <= (op == OP_DIV) ? abs32(src_a) : src_a;
        div_b_p0 <= (op == OP_DIV) ? abs32(src_b) : src_b;
        neg_q    <= (op == OP_DIV) && (src_a[31] ^ src_b[31]);
        neg_r    <= (op == OP_DIV) && src_a[31];
      end else if (is_div) begin
        hi_r <= src_a;
        lo_r <= 32'hFFFF_FFFF;
      end else if (op == OP_MTHI) begin
        hi_r <= src_a;
        lo_r <= 32'd0;
      end else begin
        hi_r <= 32'd0;
        lo_r <= src_a;
      end
    end else if (state == S_MUL) begin
      hi_r <= product[63:32];
      lo_r <= product[31:0];
    end else if (state == S_DIV) begin
      hi_r <= q_bit ? rem_diff[31:0] : rem_sh[31:0];
      lo_r <= {lo_r[30:0], q_bit};
    end
  end

  // Write bus: live only in DONE and suppressed by a same-cycle flush.
  logic fire;

  assign fire     = (state == S_DONE) && !cancel;
  assign hilo_bus = fire ? {hi_we_r, lo_we_r, cond_neg(hi_r, neg_r), cond_neg(lo_r, neg_q)}
                         : 66'd0;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed bench for hilo_md_ctrl: expected HI/LO writes are queued when an
// operation is issued and compared when the DUT raises a write enable.
module tb_hilo_md_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        stallreq, busy;
  logic [65:0] hilo_bus;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [65:0] v;
    logic [65:0] m;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [65:0] M_ALL = {66{1'b1}};
  localparam logic [65:0] M_HI  = {2'b11, 32'hFFFF_FFFF, 32'h0};
  localparam logic [65:0] M_LO  = {2'b11, 32'h0, 32'hFFFF_FFFF};

  always #5 clk = ~clk;

  hilo_md_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .stallreq (stallreq),
    .busy     (busy),
    .hilo_bus (hilo_bus)
  );

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference results computed with wide arithmetic, independent of the DUT algorithm.
  function automatic logic [65:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    model = 66'd0;
    case (o)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        model = {2'b11, p};
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        model = {2'b11, p};
      end
      3'd2: begin
        if (b == 32'd0) model = {2'b11, a, 32'hFFFF_FFFF};
        else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          model = {2'b11, r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) model = {2'b11, a, 32'hFFFF_FFFF};
        else model = {2'b11, a % b, a / b};
      end
      default: model = 66'd0;
    endcase
  endfunction

  // Issue one op, count stall cycles from issue, compare the single write.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [65:0] ev, input logic [65:0] em,
                       input int lat, input int stl, input int poke);
    int  sc;
    bit  got;
    exp_t e;
    sb_q.push_back('{ev, em});
    @(negedge clk);
    start = 1'b1; cancel = 1'b0; op = o; src_a = a; src_b = b;
    #1;
    check("idle_at_start", {65'd0, busy}, 66'd0);
    sc  = stallreq ? 1 : 0;
    got = 1'b0;
    for (int k = 1; k <= 45 && !got; k++) begin
      @(negedge clk);
      if (k == poke) begin
        start = 1'b1; op = 3'b100; src_a = 32'hDEAD_BEEF; src_b = 32'd0;
      end else begin
        start = 1'b0;
      end
      #1;
      if (stallreq) sc++;
      if (hilo_bus[65:64] != 2'b00) begin
        got = 1'b1;
        check("latency", 66'(k), 66'(lat));
        e = sb_q.pop_front();
        check("hilo_bus", hilo_bus & e.m, e.v & e.m);
      end
    end
    start = 1'b0;
    check("write_seen", {65'd0, got}, 66'd1);
    check("stall_cycles", 66'(sc), 66'(stl));
    @(negedge clk);
    #1;
    check("single_pulse", {64'd0, hilo_bus[65:64]}, 66'd0);
  endtask

  initial begin
    int wr;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          rl, rs;

    rst = 1'b1; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {65'd0, busy}, 66'd0);
    check("rst_stall", {65'd0, stallreq}, 66'd0);
    check("rst_bus", hilo_bus, 66'd0);
    @(negedge clk);
    rst = 1'b0;

    // Multiply, signed and unsigned.
    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFF1}, M_ALL, 2, 2, 0);
    do_op(3'd1, 32'hFFFF_FFFD, 32'd5, {2'b11, 32'h0000_0004, 32'hFFFF_FFF1}, M_ALL, 2, 2, 0);

    // Divide, including the signed overflow corner and divide by zero.
    do_op(3'd3, 32'd100, 32'd7, {2'b11, 32'd2, 32'd14}, M_ALL, 33, 33, 0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, M_ALL, 33, 33, 0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {2'b11, 32'h0, 32'h8000_0000}, M_ALL, 33, 33, 0);
    do_op(3'd3, 32'd5, 32'd0, {2'b11, 32'd5, 32'hFFFF_FFFF}, M_ALL, 1, 0, 0);

    // Moves into HI / LO.
    do_op(3'd4, 32'h1234_5678, 32'd0, {2'b10, 32'h1234_5678, 32'h0}, M_HI, 1, 0, 0);
    do_op(3'd5, 32'hCAFE_F00D, 32'd0, {2'b01, 32'h0, 32'hCAFE_F00D}, M_LO, 1, 0, 0);

    // A start presented while dividing must not disturb the divide.
    do_op(3'd3, 32'd100, 32'd7, {2'b11, 32'd2, 32'd14}, M_ALL, 33, 33, 5);

    // Flush mid-divide, then an immediately following MULT.
    @(negedge clk);
    start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
    wr = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) cancel = 1'b1;
      #1;
      if (hilo_bus[65:64] != 2'b00) wr++;
      if (k == 10) check("cancel_stall_low", {65'd0, stallreq}, 66'd0);
    end
    do_op(3'd0, 32'd7, 32'hFFFF_FFFE, model(3'd0, 32'd7, 32'hFFFF_FFFE), M_ALL, 2, 2, 0);
    check("cancel_no_write", 66'(wr), 66'd0);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", {65'd0, busy}, 66'd0);
    check("midrst_stall", {65'd0, stallreq}, 66'd0);
    check("midrst_bus", hilo_bus, 66'd0);
    wr = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (hilo_bus[65:64] != 2'b00) wr++;
    end
    check("midrst_no_write", 66'(wr), 66'd0);

    // Flush in DONE suppresses the write.
    @(negedge clk);
    start = 1'b1; op = 3'd5; src_a = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0; cancel = 1'b1;
    #1;
    check("done_cancel_we", {64'd0, hilo_bus[65:64]}, 66'd0);
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("done_cancel_idle", {65'd0, busy}, 66'd0);

    // Flush in IDLE with start: not accepted.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd3;
    #1;
    check("idle_cancel_stall", {65'd0, stallreq}, 66'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1;
    check("idle_cancel_busy", {65'd0, busy}, 66'd0);

    // Reserved opcode: start ignored.
    @(negedge clk);
    start = 1'b1; op = 3'b110; src_a = 32'd9; src_b = 32'd9;
    #1;
    check("noop_stall", {65'd0, stallreq}, 66'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("noop_busy", {65'd0, busy}, 66'd0);
    wr = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (hilo_bus[65:64] != 2'b00) wr++;
    end
    check("noop_no_write", 66'(wr), 66'd0);

    // A few pseudo-random mul/div ops against the reference model.
    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : $urandom;
      if (i == 4) rb = 32'd1 + 32'($urandom_range(0, 300));
      if (ro <= 3'd1) begin rl = 2; rs = 2; end
      else if (rb == 32'd0) begin rl = 1; rs = 0; end
      else begin rl = 33; rs = 33; end
      do_op(ro, ra, rb, model(ro, ra, rb), M_ALL, rl, rs, 0);
    end

    check("scoreboard_empty", 66'(sb_q.size()), 66'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
